// File: rtl/elevator_panel_pkg.sv
// Shared types and constants for the elevator operator panel.
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_DOWN = 2'b01,
    DIR_UP   = 2'b10
  } dir_e;

  // Active-high segments {g,f,e,d,c,b,a}; entry i is decimal digit i.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Floors are shown 1-based; anything outside the building shows a dash.
  function automatic logic [6:0] floor_to_seg(input int unsigned floor_val,
                                               input int unsigned n_floors);
    logic [3:0] digit;
    digit = 4'(floor_val + 1);
    if (floor_val >= n_floors || floor_val > 8) return SEG_DASH;
    return SEG_DIGIT[digit];
  endfunction

endpackage

// File: rtl/elevator_panel_if.sv
// Board-side bundle of the elevator panel: raw buttons, controller state, commands and lamps.
interface elevator_panel_if #(
  parameter int N = 4,
  parameter int M = 2
);
  logic [N-1:0] Btn_F;
  logic [N-2:0] Btn_U;
  logic [N-2:0] Btn_D;
  logic         Btn_open;
  logic         Btn_close;
  logic         Btn_hold;
  logic         Btn_emerg;
  logic [M-1:0] Floor;
  logic [1:0]   Direction;
  logic         Door_open;
  logic [N-1:0] F_led;
  logic [N-2:0] U_led;
  logic [N-2:0] D_led;
  logic [N-1:0] F;
  logic [N-2:0] U;
  logic [N-2:0] D;
  logic         Open;
  logic         Close;
  logic         Door_hold;
  logic         Emergency;
  logic [6:0]   Seg;
  logic         Arrow_up;
  logic         Arrow_down;
  logic         Door_lamp;
  logic         Emerg_lamp;
  logic [N-1:0] Lamp_F;
  logic [N-2:0] Lamp_U;
  logic [N-2:0] Lamp_D;

  modport master (
    output Btn_F, Btn_U, Btn_D, Btn_open, Btn_close, Btn_hold, Btn_emerg,
    output Floor, Direction, Door_open, F_led, U_led, D_led,
    input  F, U, D, Open, Close, Door_hold, Emergency,
    input  Seg, Arrow_up, Arrow_down, Door_lamp, Emerg_lamp, Lamp_F, Lamp_U, Lamp_D
  );

  modport slave (
    input  Btn_F, Btn_U, Btn_D, Btn_open, Btn_close, Btn_hold, Btn_emerg,
    input  Floor, Direction, Door_open, F_led, U_led, D_led,
    output F, U, D, Open, Close, Door_hold, Emergency,
    output Seg, Arrow_up, Arrow_down, Door_lamp, Emerg_lamp, Lamp_F, Lamp_U, Lamp_D
  );
endinterface

// File: rtl/elevator_panel_button_debouncer.sv
// One raw push-button: 2-flop synchroniser, stability counter, debounced level and rise pulse.
module button_debouncer #(
  parameter int Deb_cyc   = 8,
  parameter int Deb_width = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [Deb_width-1:0] CNT_LAST = Deb_width'(Deb_cyc - 1);

  logic                 sync1_reg, sync2_reg;
  logic                 stable_reg, stable_next, stable_d_reg;
  logic                 rise_reg;
  logic [Deb_width-1:0] cnt_reg, cnt_next;

  // The counter only runs while the input disagrees with the accepted state.
  always_comb begin
    cnt_next    = '0;
    stable_next = stable_reg;
    if (sync2_reg != stable_reg) begin
      if (cnt_reg == CNT_LAST) stable_next = sync2_reg;
      else                     cnt_next    = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      cnt_reg      <= '0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      rise_reg     <= 1'b0;
    end else begin
      sync1_reg    <= btn_raw;
      sync2_reg    <= sync1_reg;
      cnt_reg      <= cnt_next;
      stable_reg   <= stable_next;
      stable_d_reg <= stable_reg;
      rise_reg     <= stable_reg & ~stable_d_reg;
    end
  end

  // Level is taken from the delayed copy so it lines up with the rise pulse.
  assign level = stable_d_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/elevator_panel.sv
// Operator panel front end: conditions buttons into controller commands and drives lamps/7-seg.
// Define ELEVATOR_PANEL_BLINK_EN to make the emergency lamp blink while the latch is set.
module elevator_panel
  import elevator_pkg::*;
#(
  parameter int N           = 4,
  parameter int M           = 2,
  parameter int Deb_cyc     = 8,
  parameter int Deb_width   = 4,
  parameter int Blink_cyc   = 12,
  parameter int Blink_width = 4
) (
  input logic             CLK,
  input logic             RST,
  elevator_panel_if.slave bus
);

  // All raw buttons share one debouncer array; these are the slice offsets.
  localparam int NB      = 3 * N + 2;
  localparam int U_LO    = N;
  localparam int D_LO    = 2 * N - 1;
  localparam int OPEN_I  = 3 * N - 2;
  localparam int CLOSE_I = 3 * N - 1;
  localparam int HOLD_I  = 3 * N;
  localparam int EMERG_I = 3 * N + 1;

  logic [NB-1:0] btn_raw, btn_lvl, btn_rise;
  logic [M-1:0]  floor_in;
  logic [N-1:0]  f_reg, lamp_f_reg;
  logic [N-2:0]  u_reg, d_reg, lamp_u_reg, lamp_d_reg;
  logic          open_reg, close_reg, hold_reg;
  logic          emerg_latch_reg, emerg_latch_next;
  logic [6:0]    seg_reg;
  logic          arrow_up_reg, arrow_down_reg, door_lamp_reg, emerg_lamp_reg;
  logic          unused_btn;

  assign btn_raw  = {bus.Btn_emerg, bus.Btn_hold, bus.Btn_close, bus.Btn_open,
                     bus.Btn_D, bus.Btn_U, bus.Btn_F};
  assign floor_in = bus.Floor;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      button_debouncer #(
        .Deb_cyc   (Deb_cyc),
        .Deb_width (Deb_width)
      ) u_deb (
        .CLK     (CLK),
        .RST     (RST),
        .btn_raw (btn_raw[gi]),
        .level   (btn_lvl[gi]),
        .rise    (btn_rise[gi])
      );
    end
  endgenerate

  // Close must see the latch value after this cycle's emergency toggle.
  assign emerg_latch_next = emerg_latch_reg ^ btn_rise[EMERG_I];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      f_reg           <= '0;
      u_reg           <= '0;
      d_reg           <= '0;
      open_reg        <= 1'b0;
      close_reg       <= 1'b0;
      hold_reg        <= 1'b0;
      emerg_latch_reg <= 1'b0;
      seg_reg         <= '0;
      arrow_up_reg    <= 1'b0;
      arrow_down_reg  <= 1'b0;
      door_lamp_reg   <= 1'b0;
      lamp_f_reg      <= '0;
      lamp_u_reg      <= '0;
      lamp_d_reg      <= '0;
    end else begin
      f_reg           <= btn_rise[N-1:0] & ~bus.F_led;
      u_reg           <= btn_rise[D_LO-1:U_LO] & ~bus.U_led;
      d_reg           <= btn_rise[OPEN_I-1:D_LO] & ~bus.D_led;
      open_reg        <= btn_lvl[OPEN_I];
      close_reg       <= btn_lvl[CLOSE_I] & ~btn_lvl[OPEN_I] & ~emerg_latch_next;
      hold_reg        <= btn_rise[HOLD_I];
      emerg_latch_reg <= emerg_latch_next;
      seg_reg         <= floor_to_seg(32'(floor_in), 32'(N));
      arrow_up_reg    <= (bus.Direction == DIR_UP);
      arrow_down_reg  <= (bus.Direction == DIR_DOWN);
      door_lamp_reg   <= bus.Door_open;
      lamp_f_reg      <= bus.F_led;
      lamp_u_reg      <= bus.U_led;
      lamp_d_reg      <= bus.D_led;
    end
  end

`ifdef ELEVATOR_PANEL_BLINK_EN
  localparam logic [Blink_width-1:0] BLINK_LAST = Blink_width'(Blink_cyc - 1);
  logic [Blink_width-1:0] blink_cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_cnt_reg  <= '0;
      emerg_lamp_reg <= 1'b0;
    end else if (!emerg_latch_next) begin
      blink_cnt_reg  <= '0;
      emerg_lamp_reg <= 1'b0;
    end else if (!emerg_latch_reg) begin
      blink_cnt_reg  <= '0;
      emerg_lamp_reg <= 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg  <= '0;
      emerg_lamp_reg <= ~emerg_lamp_reg;
    end else begin
      blink_cnt_reg  <= blink_cnt_reg + 1'b1;
    end
  end
`else
  localparam int unused_blink_cfg = Blink_cyc + Blink_width;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) emerg_lamp_reg <= 1'b0;
    else     emerg_lamp_reg <= emerg_latch_next;
  end
`endif

  // Levels of pulse-type buttons and rises of level-type buttons are not needed.
  assign unused_btn = ^{btn_lvl[EMERG_I:HOLD_I], btn_lvl[OPEN_I-1:0], btn_rise[CLOSE_I:OPEN_I]};

  assign bus.F          = f_reg;
  assign bus.U          = u_reg;
  assign bus.D          = d_reg;
  assign bus.Open       = open_reg;
  assign bus.Close      = close_reg;
  assign bus.Door_hold  = hold_reg;
  assign bus.Emergency  = emerg_latch_reg;
  assign bus.Seg        = seg_reg;
  assign bus.Arrow_up   = arrow_up_reg;
  assign bus.Arrow_down = arrow_down_reg;
  assign bus.Door_lamp  = door_lamp_reg;
  assign bus.Emerg_lamp = emerg_lamp_reg;
  assign bus.Lamp_F     = lamp_f_reg;
  assign bus.Lamp_U     = lamp_u_reg;
  assign bus.Lamp_D     = lamp_d_reg;

endmodule

// File: doc/elevator_panel.md
Name: elevator_panel

Overview:
- Operator-side front end for the elevator controller.
- Conditions raw car and hall push-buttons (synchronise, debounce, edge-detect) into the request and command signals the controller consumes: F, U, D, Open, Close, Door_hold, Emergency.
- Renders the controller's state (Floor, Direction, Door_open, request LEDs) onto user-facing lamps and a 7-segment floor digit.
- Sits between board I/O and the controller.

Parameters:
- N, 4, number of floors (2..9).
- M, 2, floor encoding width, ceil(log2 N).
- Deb_cyc, 8, consecutive stable cycles required to accept a button change (1..2^Deb_width-1).
- Deb_width, 4, debounce counter width.
- Blink_cyc, 12, half-period of the emergency blink in cycles (used only with the optional feature).
- Blink_width, 4, blink counter width.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- Btn_F  in  N  raw car floor buttons (asynchronous, bouncy)
- Btn_U  in  N-1  raw hall up buttons, floors 0..N-2
- Btn_D  in  N-1  raw hall down buttons, floors 1..N-1
- Btn_open, Btn_close, Btn_hold, Btn_emerg  in  1 each  raw car buttons
- Floor  in  M  controller current floor
- Direction  in  2  controller direction: 00 idle/doors, 01 down, 10 up
- Door_open  in  1  controller door state
- F_led  in  N  controller pending floor requests
- U_led  in  N-1  controller pending up requests
- D_led  in  N-1  controller pending down requests
- F  out  N  one-cycle floor request pulses
- U  out  N-1  one-cycle up request pulses
- D  out  N-1  one-cycle down request pulses
- Open  out  1  level, high while open button held
- Close  out  1  level, high while close button held
- Door_hold  out  1  one-cycle pulse per hold press
- Emergency  out  1  latched emergency level
- Seg  out  7  active-high segments {g,f,e,d,c,b,a} showing Floor+1
- Arrow_up  out  1  up arrow lamp
- Arrow_down  out  1  down arrow lamp
- Door_lamp  out  1  door-open lamp
- Emerg_lamp  out  1  emergency lamp
- Lamp_F  out  N  registered copy of F_led
- Lamp_U  out  N-1  registered copy of U_led
- Lamp_D  out  N-1  registered copy of D_led

Behaviour:
- Reset: all outputs 0, all synchronisers 0, debounced states 0 (released), debounce counters 0, emergency latch 0, blink counter 0.
- Reset is asynchronous and may assert mid-operation; it clears everything, including any pulse in flight.
- Synchronisation: every raw button passes through a 2-flop synchroniser.

Debounce, per button:
- The counter clears whenever the synchronised value equals the stable state.
- Otherwise the counter increments. When it reaches Deb_cyc, the stable state flips and the counter clears.
- A glitch shorter than Deb_cyc cycles produces no change.

Press and release latency:
- The rising edge of the stable state registers a one-cycle pulse.
- A clean press sampled at edge 0 gives a pulse high for exactly one cycle after edge Deb_cyc+3.
- Release latency is identical.

Per-button outputs:
- F[i], U[i], D[i]: rising pulse, suppressed if the matching F_led/U_led/D_led bit is already 1 in that cycle.
- Open: registered debounced level.
- Close: registered debounced level AND NOT Open-level AND NOT Emergency; Open wins when both are held.
- Door_hold: rising pulse; it is not suppressed.
- Emergency: each Btn_emerg rising pulse toggles the latch; Emergency = latch.

Display, all registered with 1-cycle latency from inputs:
- Seg shows the decimal digit Floor+1.
- Floor >= N shows a dash (g only).
- Arrow_up = (Direction==10); Arrow_down = (Direction==01).
- Direction 11 (illegal): both arrows 0.
- Door_lamp = Door_open.
- Emerg_lamp = Emergency latch.

Simultaneous events:
- Independent buttons are processed in parallel, so multiple F/U/D pulses may coincide in one cycle.
- An emergency toggle and a Close press in the same cycle: Close is evaluated against the new latch value.

Optional Feature:
- Macro: ELEVATOR_PANEL_BLINK_EN.
- Defined: while the emergency latch is 1, Emerg_lamp toggles every Blink_cyc cycles, starting high on the cycle the latch sets. The blink counter and lamp clear when the latch clears.
- Undefined: Emerg_lamp is a steady copy of the latch and no blink counter is instantiated.

Decomposition:
- Shared package elevator_pkg holds:
  - DIR_IDLE=2'b00, DIR_DOWN=2'b01, DIR_UP=2'b10
  - SEG_DIGIT[0..9] and SEG_DASH 7-bit constants
- Sub-module button_debouncer (parameters Deb_cyc, Deb_width): 2-flop synchroniser, counter, stable state, rise pulse. Outputs level and rise.
- One instance per raw button via generate loops.

Test Plan:
- Btn_F[2] held clean from edge 0, Deb_cyc=8, F_led=0 -> F=4'b0100 for exactly one cycle after edge 11, 0 otherwise; release gives no pulse.
- Btn_U[1] bounces 1/0 every 3 cycles for 30 cycles, then held high -> single U[1] pulse Deb_cyc+3 cycles after the final rising edge.
- Btn_D[0] clean press with D_led=3'b001 -> D stays 0.
- Btn_open and Btn_close held together -> Open=1, Close=0. Release open only -> Close=1 Deb_cyc+3 cycles later.
- Two Btn_emerg presses -> Emergency 0->1->0. While 1, Btn_close held -> Close=0. With ELEVATOR_PANEL_BLINK_EN, Blink_cyc=12 -> Emerg_lamp period 24.
- Floor=2'd3, Direction=10 -> next cycle Seg=digit 4, Arrow_up=1. Direction=11 -> both arrows 0. Assert RST mid-pulse -> all outputs 0 immediately.
